// File: rtl/packet_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module   : packet_buffer_reader
//  Purpose  : Reads a buffer word stream made of a header word followed by
//             payload words, and turns it into a packet beat stream.
//             Header: [15:0] = packet length in bytes, [31:16] = interface id.
//             Payload is packed little-endian: byte n sits in word n/4, lane n%4.
//             Zero-length or oversize headers raise a one-cycle hdr_err.
//             Oversize packets are then consumed silently. A zero-length
//             packet has no payload words, so the next word is a header.
//  Ports    : clk, rst_n (async, active-low)
//             s_data/s_valid/s_ready            - buffer word stream in
//             m_data/m_keep/m_last/m_user/
//             m_valid/m_ready                   - packet beat stream out
//             hdr_err                           - rejected-header pulse
//             busy                              - high outside HEADER state
//             pkt_count/err_count               - only with
//                                                 PACKET_BUFFER_READER_STATS_EN
//  Options  : `define PACKET_BUFFER_READER_STATS_EN adds the packet and error
//             counters.
//  Revision : 1.0 - initial release
// ============================================================================
module packet_buffer_reader #(
    parameter int MAX_LEN = 1500,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic [15:0] m_user,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        hdr_err,
    output logic        busy
`ifdef PACKET_BUFFER_READER_STATS_EN
    ,
    output logic [31:0] pkt_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [31:0] c_max_len = 32'(MAX_LEN);

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   remaining_q;   // bytes left in PAYLOAD, words left in DROP
    logic [15:0]        id_q;
    logic [31:0]        m_data_q;
    logic [3:0]         m_keep_q;
    logic               m_last_q;
    logic [15:0]        m_user_q;
    logic               m_valid_q;
    logic               hdr_err_q;
`ifdef PACKET_BUFFER_READER_STATS_EN
    logic [31:0]        pkt_count_q;
    logic [15:0]        err_count_q;
`endif

    logic               w_out_free;
    logic               w_s_ready;
    logic               w_s_xfer;
    logic [15:0]        w_len;
    logic [CNT_W-1:0]   w_len_cnt;
    logic [CNT_W-1:0]   w_words;
    logic               w_rem_le4;

    // The output register can take a new word when empty or draining this cycle.
    // HEADER also waits on it, so a header cannot overtake a stalled final beat.
    assign w_out_free = !m_valid_q || m_ready;

    always_comb begin
        w_s_ready = 1'b0;
        case (state_q)
            HEADER:  w_s_ready = w_out_free;
            PAYLOAD: w_s_ready = w_out_free;
            DROP:    w_s_ready = 1'b1;
            default: w_s_ready = 1'b0;
        endcase
    end

    assign w_s_xfer  = s_valid && w_s_ready;
    assign w_len     = s_data[15:0];
    assign w_len_cnt = CNT_W'(w_len);
    assign w_words   = (w_len_cnt + CNT_W'(3)) >> 2;
    assign w_rem_le4 = (remaining_q <= CNT_W'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HEADER;
            remaining_q <= '0;
            id_q        <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_user_q    <= '0;
            m_valid_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
`ifdef PACKET_BUFFER_READER_STATS_EN
            pkt_count_q <= '0;
            err_count_q <= '0;
`endif
        end else begin
            hdr_err_q <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
`ifdef PACKET_BUFFER_READER_STATS_EN
            if (m_valid_q && m_ready && m_last_q) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
`endif
            case (state_q)
                HEADER: begin
                    if (w_s_xfer) begin
                        if (w_len == 16'd0) begin
                            hdr_err_q <= 1'b1;
                        end else if (32'(w_len) > c_max_len) begin
                            hdr_err_q   <= 1'b1;
                            remaining_q <= w_words;
                            state_q     <= DROP;
                        end else begin
                            id_q        <= s_data[31:16];
                            remaining_q <= w_len_cnt;
                            state_q     <= PAYLOAD;
                        end
`ifdef PACKET_BUFFER_READER_STATS_EN
                        if ((w_len == 16'd0 || 32'(w_len) > c_max_len) &&
                            err_count_q != 16'hFFFF) begin
                            err_count_q <= err_count_q + 16'd1;
                        end
`endif
                    end
                end
                PAYLOAD: begin
                    if (w_s_xfer) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_user_q  <= id_q;
                        if (w_rem_le4) begin
                            m_last_q <= 1'b1;
                            // remaining is 1..4 here; 4 wraps to lane code 0
                            case (remaining_q[1:0])
                                2'd1:    m_keep_q <= 4'b0001;
                                2'd2:    m_keep_q <= 4'b0011;
                                2'd3:    m_keep_q <= 4'b0111;
                                default: m_keep_q <= 4'b1111;
                            endcase
                            remaining_q <= '0;
                            state_q     <= HEADER;
                        end else begin
                            m_last_q    <= 1'b0;
                            m_keep_q    <= 4'b1111;
                            remaining_q <= remaining_q - CNT_W'(4);
                        end
                    end
                end
                DROP: begin
                    if (w_s_xfer) begin
                        // <= 1 also covers a zero word count, so the counter never wraps
                        if (remaining_q <= CNT_W'(1)) begin
                            remaining_q <= '0;
                            state_q     <= HEADER;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                end
                default: state_q <= HEADER;
            endcase
        end
    end

    assign s_ready = w_s_ready;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_user  = m_user_q;
    assign m_valid = m_valid_q;
    assign hdr_err = hdr_err_q;
    assign busy    = (state_q != HEADER);
`ifdef PACKET_BUFFER_READER_STATS_EN
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packet_buffer_reader
//  Purpose  : Self-checking bench for packet_buffer_reader. Packets are built
//             from byte lists, and expected beats come from a packet-level
//             model of the header/payload/drop rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_packet_buffer_reader;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [15:0] u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [15:0] m_user;
    logic        m_valid;
    logic        m_ready;
    logic        hdr_err;
    logic        busy;
`ifdef PACKET_BUFFER_READER_STATS_EN
    logic [31:0] pkt_count;
    logic [15:0] err_count;
`endif

    packet_buffer_reader #(.MAX_LEN(1500), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_user(m_user),
        .m_valid(m_valid), .m_ready(m_ready),
        .hdr_err(hdr_err), .busy(busy)
`ifdef PACKET_BUFFER_READER_STATS_EN
        , .pkt_count(pkt_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words[$];
    bit          is_pl[$];
    beat_t       exp_b[$];
    beat_t       obs[$];
    int          exp_err;
    int          obs_err, stall_bad, lat_bad, idle_cnt;
    bit          timed_out;

    // ---------------- stimulus builders ----------------
    task automatic add_packet(input int len, input logic [15:0] id);
        logic [7:0] b[$];
        words.push_back({id, 16'(len)});
        for (int n = 0; n < len; n++) b.push_back(8'($urandom));
        while (b.size() % 4 != 0) b.push_back(8'($urandom));
        for (int w = 0; w < b.size() / 4; w++)
            words.push_back({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    endtask

    task automatic add_oversize(input int len, input logic [15:0] id);
        words.push_back({id, 16'(len)});
        for (int w = 0; w < (len + 3) / 4; w++) words.push_back($urandom);
    endtask

    // ---------------- packet-level reference model ----------------
    function automatic void model();
        int i = 0;
        exp_b.delete(); is_pl.delete(); exp_err = 0;
        while (i < words.size()) begin
            int          len;
            logic [15:0] id;
            len = int'(words[i][15:0]);
            id  = words[i][31:16];
            is_pl.push_back(1'b0);
            i++;
            if (len == 0) begin
                exp_err++;
            end else if (len > 1500) begin
                exp_err++;
                for (int j = 0; j < (len + 3) / 4 && i < words.size(); j++) begin
                    is_pl.push_back(1'b0);
                    i++;
                end
            end else begin
                for (int b = 0; b < len && i < words.size(); b += 4) begin
                    beat_t e;
                    int    r;
                    r   = len - b;
                    e.d = words[i];
                    e.k = (r >= 4) ? 4'hF : 4'((1 << r) - 1);
                    e.l = (r <= 4);
                    e.u = id;
                    exp_b.push_back(e);
                    is_pl.push_back(1'b1);
                    i++;
                end
            end
        end
    endfunction

    // ---------------- driver + monitor (records, does not judge) ----------------
    // rmode: 0 m_ready always 1, 1 toggling, 2 random. vmode: 0 s_valid dense, 1 random gaps.
    task automatic run_stream(input int rmode, input int vmode, input int max_cycles);
        int    idx = 0;
        int    cyc = 0;
        int    lat_q[$];
        bit    have_stall = 1'b0;
        beat_t stall_b, cur;
        obs.delete();
        obs_err = 0; stall_bad = 0; lat_bad = 0; idle_cnt = 0; timed_out = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (idx < words.size() && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = words[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = cyc[0];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            cur = {m_data, m_keep, m_last, m_user};
            if (hdr_err) obs_err++;
            if (have_stall && (!m_valid || cur != stall_b)) stall_bad++;
            have_stall = m_valid && !m_ready;
            stall_b    = cur;
            if (m_valid && m_ready) begin
                obs.push_back(cur);
                if (rmode == 0) begin
                    if (lat_q.size() == 0) lat_bad++;
                    else if (lat_q.pop_front() + 1 != cyc) lat_bad++;
                end
            end
            if (s_valid && s_ready) begin
                if (is_pl[idx]) lat_q.push_back(cyc);
                idx++;
            end else if (s_valid && rmode == 0) begin
                idle_cnt++;
            end
            if (idx == words.size() && !s_valid && !m_valid) break;
            if (cyc > max_cycles) begin
                timed_out = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_valid, m_last, m_keep, m_data, m_user, hdr_err} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h u=%h e=%b, expected all zero",
                     m_valid, m_last, m_keep, m_data, m_user, hdr_err);
        end
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_ready: got busy=%b s_ready=%b, expected 0/1", busy, s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        beat_t want;
        words.delete();
        words.push_back(32'h0003_0005);
        words.push_back(32'h4433_2211);
        words.push_back(32'h0000_0055);
        model();
        run_stream(0, 0, 200);
        want = {32'h0000_0055, 4'b0001, 1'b1, 16'h0003};
        n_checks++;
        if (obs.size() !== 2 || timed_out) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats (timeout=%0d), expected 2", obs.size(), timed_out);
        end else begin
            n_checks++;
            if (obs[0] !== {32'h4433_2211, 4'b1111, 1'b0, 16'h0003}) begin
                n_fail++;
                $display("FAIL basic_beat0: got %h, expected %h", obs[0],
                         {32'h4433_2211, 4'b1111, 1'b0, 16'h0003});
            end
            n_checks++;
            if (obs[1] !== want) begin
                n_fail++;
                $display("FAIL basic_beat1: got %h, expected %h", obs[1], want);
            end
        end
    endtask

    task automatic test_back_to_back();
        words.delete();
        add_packet(4, 16'h00A1);
        add_packet(8, 16'h00B2);
        model();
        run_stream(0, 0, 200);
        n_checks++;
        if (obs.size() !== 3 || timed_out) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats, expected 3", obs.size());
        end else begin
            n_checks++;
            if ({obs[0].l, obs[1].l, obs[2].l} !== 3'b101) begin
                n_fail++;
                $display("FAIL b2b_last: got %b, expected 101", {obs[0].l, obs[1].l, obs[2].l});
            end
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h, expected %h", i, obs[i], exp_b[i]);
            end
        end
        n_checks++;
        if (lat_bad !== 0 || idle_cnt !== 0) begin
            n_fail++;
            $display("FAIL b2b_timing: got latency errors=%0d idle cycles=%0d, expected 0/0", lat_bad, idle_cnt);
        end
    endtask

    task automatic test_bad_headers();
        words.delete();
        words.push_back(32'h0007_0000);
        add_packet(5, 16'h0011);
        add_oversize(1501, 16'h0022);
        add_packet(9, 16'h0033);
        model();
        run_stream(0, 0, 1000);
        n_checks++;
        if (obs_err !== 2 || timed_out) begin
            n_fail++;
            $display("FAIL bad_hdr_err: got %0d hdr_err pulses, expected 2", obs_err);
        end
        n_checks++;
        if (obs.size() !== exp_b.size()) begin
            n_fail++;
            $display("FAIL bad_hdr_count: got %0d beats, expected %0d", obs.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL bad_hdr_beat%0d: got %h, expected %h", i, obs[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_stall();
        words.delete();
        add_packet(12, 16'h0C0C);
        model();
        run_stream(1, 0, 200);
        n_checks++;
        if (obs.size() !== 3 || timed_out) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats, expected 3", obs.size());
        end else begin
            n_checks++;
            if (obs[2].k !== 4'b1111 || obs[2].l !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_last: got keep=%b last=%b, expected 1111/1", obs[2].k, obs[2].l);
            end
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got %h, expected %h", i, obs[i], exp_b[i]);
            end
        end
        n_checks++;
        if (stall_bad !== 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d unstable stalled cycles, expected 0", stall_bad);
        end
    endtask

    task automatic test_random();
        words.delete();
        for (int p = 0; p < 25; p++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) words.push_back({16'($urandom), 16'd0});
            else if (sel == 1) add_oversize($urandom_range(1501, 1540), 16'($urandom));
            else add_packet($urandom_range(1, 40), 16'($urandom));
        end
        model();
        run_stream(2, 1, 20000);
        n_checks++;
        if (obs.size() !== exp_b.size() || timed_out) begin
            n_fail++;
            $display("FAIL rand_count: got %0d beats (timeout=%0d), expected %0d", obs.size(), timed_out, exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got %h, expected %h", i, obs[i], exp_b[i]);
            end
        end
        n_checks++;
        if (obs_err !== exp_err || stall_bad !== 0) begin
            n_fail++;
            $display("FAIL rand_err_stall: got errs=%0d unstable=%0d, expected %0d/0", obs_err, stall_bad, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        words.delete();
        add_packet(16, 16'h0BAD);
        m_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = words[w];
            #1;
            n_checks++;
            if (s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rmid_ready%0d: got s_ready=%b, expected 1", w, s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got m_valid=%b busy=%b, expected 1/1", m_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_last, m_keep, m_data, m_user, hdr_err, busy} !== 56'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got v=%b l=%b k=%h d=%h u=%h e=%b busy=%b, expected all zero",
                     m_valid, m_last, m_keep, m_data, m_user, hdr_err, busy);
        end
`ifdef PACKET_BUFFER_READER_STATS_EN
        n_checks++;
        if (pkt_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_stats: got pkt=%0d err=%0d, expected 0/0", pkt_count, err_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        words.delete();
        add_packet(6, 16'h0606);
        model();
        run_stream(0, 0, 200);
        n_checks++;
        if (obs.size() !== 2 || obs_err !== 0 || timed_out) begin
            n_fail++;
            $display("FAIL rmid_after_count: got %0d beats errs=%0d, expected 2/0", obs.size(), obs_err);
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL rmid_beat%0d: got %h, expected %h", i, obs[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_headers();
        test_stall();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
